seg7_scan: RTL and testbench
============================

# seg7_scan

Parametrised multiplexed seven-segment display driver, successor to the fixed four-digit BCD scanner. It time-multiplexes `DIGITS` common-anode digits from a single system clock using an internal prescaler, so no external 1 kHz clock is needed. A double-buffered input snapshot prevents frame tearing, and the block adds per-digit decimal points, leading-zero blanking and a frame-done strobe. It sits between the CPU's display register and the board's anode/segment pins.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits; legal range 1..16.
- `CLK_DIV`, default 50000: `clk` cycles per digit slot; must be at least 2.

Ports (all outputs active-low to match board pins):
- `clk`  in  1  system clock; all state is clocked on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `en`  in  1  display enable. While low, the display is blank and scanning is held.
- `load`  in  1  single-cycle request to capture `din` and `dp_mask` into the pending buffer.
- `din`  in  `4*DIGITS`  nibble per digit; `din[3:0]` is digit 0, the rightmost digit.
- `dp_mask`  in  `DIGITS`  a 1 lights the decimal point of that digit.
- `lzb`  in  1  leading-zero blanking enable.
- `an`  out  `DIGITS`  digit select; one bit low at a time.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`; low lights a segment.
- `dp`  out  1  decimal point; low lights it.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit `DIGITS-1` to digit 0.

## Operation
- **Prescaler.**
  - Counter `pcnt` has width `max(1,$clog2(CLK_DIV))` and counts 0..`CLK_DIV-1`, then wraps.
  - `tick` is asserted when `pcnt == CLK_DIV-1`.
- **Digit index.**
  - `idx` has width `max(1,$clog2(DIGITS))`.
  - On each `tick`, `idx` advances to `idx+1`, wrapping from `DIGITS-1` to 0.
  - With `DIGITS=1`, `idx` stays at 0 and every tick is a wrap.
- **Buffers.**
  - `load` writes `pend_d <= din` and `pend_p <= dp_mask`, and sets `pend_v`.
  - On a wrap tick with `pend_v=1`, the shown buffers take the pending values and `pend_v` clears.
  - If `load` coincides with a wrap tick, the shown buffers take `din`/`dp_mask` directly and `pend_v` clears.
  - A second `load` before a wrap overwrites the pending buffer (last load wins).
- **Decode.** Digits 0-9 map to:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values A-F: see Configuration.
- **Leading-zero blanking.** When `lzb=1`, digit `i` with `i>0` shows `seg=7'h7F` if the shown nibbles `DIGITS-1` down to `i` are all zero. Digit 0 is never blanked by `lzb`.
- **Decimal point.** `dp = ~shown_p[idx]`, independent of blanking.
- **Disable.**
  - While `en=0`, at every edge: `an` is all ones, `seg=7'h7F`, `dp=1`; `pcnt` and `idx` are cleared; `frame_done` is 0.
  - The `load` path remains active while disabled.
  - Scanning restarts at digit 0 after `en` rises.

## Timing
- **Reset values:**
  - `an` = all ones, `seg=7'h7F`, `dp=1`, `frame_done=0`.
  - `pcnt=0`, `idx=0`.
  - Shown and pending buffers = 0, `pend_v=0`.
- **Registered outputs.** `an`, `seg`, `dp` and `frame_done` are registered.
- **Update on a tick edge.** `idx` takes its next value. At the same edge, `an`, `seg` and `dp` are loaded with the decode of the next index, using the buffer contents in effect after that edge. The new digit therefore appears on the pins together with the `idx` change, with no extra cycle of lag.
- **Between ticks.** Outputs are held, so each digit is shown for exactly `CLK_DIV` cycles.
- **Enable edge.** After `en` rises, the first edge drives digit 0; the first tick occurs `CLK_DIV` cycles later.
- **Frame strobe.** `frame_done` is high for the single cycle following the wrap edge.
- **Load latency.** Data captured by `load` becomes visible no later than the next wrap, i.e. at most `DIGITS*CLK_DIV` cycles.
- **Reset mid-frame.** Reset aborts immediately to the reset values; pending data is lost.

## Configuration
- `SEG7_HEX_EN` defined: nibbles A-F decode to hex glyphs.
  - A=0001000, b=0000011, C=1000110
  - d=0100001, E=0000110, F=0001110
- `SEG7_HEX_EN` undefined: nibbles A-F decode to blank, `seg=7'h7F`.

## Test plan
All scenarios use `DIGITS=4`, `CLK_DIV=4` unless noted.
1. **Reset and first digit.** Reset, then `en=1`, load `din=16'h1234`, `dp_mask=4'b0010`.
   - Before the load reaches the shown buffer, the display scans zeros.
   - After the first wrap, `an` cycles 1110, 1101, 1011, 0111, each held for 4 cycles.
   - `seg` shows 0011001, 0110000, 0100100, 1111001 in that order.
   - `dp=0` only while `an=1101`.
2. **Frame strobe and tearing.** Assert `load` with `16'h9999` in mid-frame.
   - The shown data changes only at the wrap.
   - `frame_done` pulses once every 16 cycles.
3. **Coincident load.** Assert `load` exactly on the wrap tick with `16'h0007`.
   - The new data appears in the same frame.
   - `pend_v` remains 0.
4. **Leading-zero blanking.** Set `din=16'h0050` and `lzb=1`.
   - Digits 3 and 2 show 7F; digit 1 shows 0010010; digit 0 shows 1000000.
   - With `din=0`, only digit 0 shows 1000000.
5. **Disable and hex decode.** Deassert `en` mid-digit, then set `din=16'hABCD`.
   - During the disable, outputs are blank on the next edge.
   - After re-enable, the scan restarts at `an=1110`.
   - With `SEG7_HEX_EN`, the digits show d/C/b/A glyphs; without it, all four show 7F.
6. **Reset mid-frame, `DIGITS=1`.** Assert `reset` mid-frame.
   - Outputs return to the reset values immediately.
   - In a `DIGITS=1` build, `an=0` and `frame_done` pulses on every tick.

Source files
------------

// File: rtl/seg7_scan.sv
// Multiplexed common-anode seven-segment driver with prescaler, double-buffered
// snapshot, decimal points, leading-zero blanking and frame strobe. Define SEG7_HEX_EN for A-F glyphs.
module seg7_scan #(
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  lzb,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

   typedef enum logic {ST_IDLE, ST_SCAN} state_t;

   state_t                state, state_nxt;
   logic [PW-1:0]         pcnt, pcnt_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [4*DIGITS-1:0]   shown_d, shown_d_nxt, pend_d, pend_d_nxt;
   logic [DIGITS-1:0]     shown_p, shown_p_nxt, pend_p, pend_p_nxt;
   logic                  pend_v, pend_v_nxt;
   logic [DIGITS-1:0]     an_nxt, an_dec;
   logic [6:0]            seg_nxt, seg_dec;
   logic                  dp_nxt, dp_dec, fd_nxt;
   logic                  tick, wrap;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'h0:    seg_decode = 7'b1000000;
         4'h1:    seg_decode = 7'b1111001;
         4'h2:    seg_decode = 7'b0100100;
         4'h3:    seg_decode = 7'b0110000;
         4'h4:    seg_decode = 7'b0011001;
         4'h5:    seg_decode = 7'b0010010;
         4'h6:    seg_decode = 7'b0000010;
         4'h7:    seg_decode = 7'b1111000;
         4'h8:    seg_decode = 7'b0000000;
         4'h9:    seg_decode = 7'b0010000;
`ifdef SEG7_HEX_EN
         4'hA:    seg_decode = 7'b0001000;
         4'hB:    seg_decode = 7'b0000011;
         4'hC:    seg_decode = 7'b1000110;
         4'hD:    seg_decode = 7'b0100001;
         4'hE:    seg_decode = 7'b0000110;
         4'hF:    seg_decode = 7'b0001110;
`endif
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   assign tick = en && (state == ST_SCAN) && (pcnt == P_LAST);
   assign wrap = tick && (idx == I_LAST);

   always_comb begin
      state_nxt   = state;
      pcnt_nxt    = pcnt;
      idx_nxt     = idx;
      shown_d_nxt = shown_d;
      shown_p_nxt = shown_p;
      pend_d_nxt  = pend_d;
      pend_p_nxt  = pend_p;
      pend_v_nxt  = pend_v;
      an_nxt      = an;
      seg_nxt     = seg;
      dp_nxt      = dp;
      fd_nxt      = 1'b0;

      if (load) begin
         pend_d_nxt = din;
         pend_p_nxt = dp_mask;
         pend_v_nxt = 1'b1;
      end
      // A load landing on the wrap bypasses the pending buffer entirely
      if (wrap) begin
         if (load) begin
            shown_d_nxt = din;
            shown_p_nxt = dp_mask;
            pend_v_nxt  = 1'b0;
         end else if (pend_v) begin
            shown_d_nxt = pend_d;
            shown_p_nxt = pend_p;
            pend_v_nxt  = 1'b0;
         end
      end

      if (!en) begin
         state_nxt = ST_IDLE;
         pcnt_nxt  = '0;
         idx_nxt   = '0;
         an_nxt    = '1;
         seg_nxt   = 7'h7F;
         dp_nxt    = 1'b1;
      end else if (state == ST_IDLE) begin
         state_nxt = ST_SCAN;
         pcnt_nxt  = '0;
         idx_nxt   = '0;
         an_nxt    = an_dec;
         seg_nxt   = seg_dec;
         dp_nxt    = dp_dec;
      end else if (tick) begin
         pcnt_nxt = '0;
         idx_nxt  = wrap ? '0 : idx + 1'b1;
         fd_nxt   = wrap;
         an_nxt   = an_dec;
         seg_nxt  = seg_dec;
         dp_nxt   = dp_dec;
      end else begin
         pcnt_nxt = pcnt + 1'b1;
      end
   end

   // Decode looks at the post-edge index and buffers so the new digit needs no extra cycle
   always_comb begin
      logic [3:0] cur_nib;
      logic       cur_p;
      logic       hi_zero;
      cur_nib = '0;
      cur_p   = 1'b0;
      hi_zero = 1'b1;
      an_dec  = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_nxt) begin
            cur_nib   = shown_d_nxt[4*i +: 4];
            cur_p     = shown_p_nxt[i];
            an_dec[i] = 1'b0;
         end
         if ((IW'(i) >= idx_nxt) && (shown_d_nxt[4*i +: 4] != 4'h0))
            hi_zero = 1'b0;
      end
      seg_dec = (lzb && (idx_nxt != '0) && hi_zero) ? 7'h7F : seg_decode(cur_nib);
      dp_dec  = ~cur_p;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         pcnt       <= '0;
         idx        <= '0;
         shown_d    <= '0;
         shown_p    <= '0;
         pend_d     <= '0;
         pend_p     <= '0;
         pend_v     <= 1'b0;
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         pcnt       <= pcnt_nxt;
         idx        <= idx_nxt;
         shown_d    <= shown_d_nxt;
         shown_p    <= shown_p_nxt;
         pend_d     <= pend_d_nxt;
         pend_p     <= pend_p_nxt;
         pend_v     <= pend_v_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         frame_done <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: expected digit slots are queued by the stimulus
// and popped by a monitor whenever {an,seg,dp} changes.
module tb_seg7_scan;

   logic        clk, reset, en, load, lzb;
   logic [15:0] din;
   logic [3:0]  dp_mask;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, frame_done;

   logic        en1;
   logic        an1, dp1, fd1;
   logic [6:0]  seg1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      logic [7:0] gap;
   } exp_t;

   exp_t sb[$];

   seg7_scan #(.DIGITS(4), .CLK_DIV(4)) u_dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
      .dp_mask(dp_mask), .lzb(lzb), .an(an), .seg(seg), .dp(dp),
      .frame_done(frame_done)
   );

   seg7_scan #(.DIGITS(1), .CLK_DIV(4)) u_one (
      .clk(clk), .reset(reset), .en(en1), .load(1'b0), .din(4'h0),
      .dp_mask(1'b0), .lzb(1'b0), .an(an1), .seg(seg1), .dp(dp1),
      .frame_done(fd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SEG7_HEX_EN
   localparam logic [6:0] G0 = 7'h21, G1 = 7'h46, G2 = 7'h03, G3 = 7'h08;
`else
   localparam logic [6:0] G0 = 7'h7F, G1 = 7'h7F, G2 = 7'h7F, G3 = 7'h7F;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                       input logic f, input logic [7:0] g);
      sb.push_back('{an: a, seg: s, dp: d, fd: f, gap: g});
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops one expectation per output change, checks hold time when given
   initial begin
      logic [11:0] prev, cur;
      int unsigned cyc, last_chg;
      exp_t e;
      prev = {4'hF, 7'h7F, 1'b1};
      cyc = 0;
      last_chg = 0;
      forever begin
         @(negedge clk);
         cyc++;
         cur = {an, seg, dp};
         if (cur !== prev) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_change: got an=%b seg=%b dp=%b, required no change (t=%0t)",
                        an, seg, dp, $time);
            end else begin
               e = sb.pop_front();
               chk("an", 32'(an), 32'(e.an));
               chk("seg", 32'(seg), 32'(e.seg));
               chk("dp", 32'(dp), 32'(e.dp));
               chk("frame_done", 32'(frame_done), 32'(e.fd));
               if (e.gap != 0) chk("hold", cyc - last_chg, 32'(e.gap));
            end
            last_chg = cyc;
            prev = cur;
         end else begin
            chk("frame_done_idle", 32'(frame_done), 32'd0);
         end
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; en1 = 1'b0; load = 1'b0; lzb = 1'b0;
      din = '0; dp_mask = '0;
      #3;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_fd", 32'(frame_done), 32'd0);
      @(negedge clk); reset = 1'b0;

      // Reset and first digit: zeros until the first wrap, then 1234
      push(4'hE, 7'h40, 1, 0, 0); push(4'hD, 7'h40, 1, 0, 4);
      push(4'hB, 7'h40, 1, 0, 4); push(4'h7, 7'h40, 1, 0, 4);
      push(4'hE, 7'h19, 1, 1, 4); push(4'hD, 7'h30, 0, 0, 4);
      push(4'hB, 7'h24, 1, 0, 4); push(4'h7, 7'h79, 1, 0, 4);
      push(4'hE, 7'h19, 1, 1, 4);
      @(negedge clk); en = 1'b1; load = 1'b1; din = 16'h1234; dp_mask = 4'b0010;
      @(negedge clk); load = 1'b0;
      wait_n(32);

      // Mid-frame load shows only after the wrap
      push(4'hD, 7'h30, 0, 0, 4); push(4'hB, 7'h24, 1, 0, 4);
      push(4'h7, 7'h79, 1, 0, 4); push(4'hE, 7'h10, 1, 1, 4);
      push(4'hD, 7'h10, 1, 0, 4); push(4'hB, 7'h10, 1, 0, 4);
      push(4'h7, 7'h10, 1, 0, 4); push(4'hE, 7'h10, 1, 1, 4);
      @(negedge clk); load = 1'b1; din = 16'h9999; dp_mask = 4'b0000;
      @(negedge clk); load = 1'b0;
      wait_n(30);

      // Load coincident with the wrap tick
      push(4'hD, 7'h10, 1, 0, 4); push(4'hB, 7'h10, 1, 0, 4);
      push(4'h7, 7'h10, 1, 0, 4); push(4'hE, 7'h78, 1, 1, 4);
      push(4'hD, 7'h40, 1, 0, 4); push(4'hB, 7'h40, 1, 0, 4);
      push(4'h7, 7'h40, 1, 0, 4); push(4'hE, 7'h78, 1, 1, 4);
      wait_n(15); load = 1'b1; din = 16'h0007;
      @(negedge clk); load = 1'b0;
      @(negedge clk); chk("pend_v_coincident", 32'(u_dut.pend_v), 32'd0);
      wait_n(15);

      // Leading-zero blanking with 0050, then all zeros
      push(4'hD, 7'h40, 1, 0, 4); push(4'hB, 7'h40, 1, 0, 4);
      push(4'h7, 7'h40, 1, 0, 4); push(4'hE, 7'h40, 1, 1, 4);
      push(4'hD, 7'h12, 1, 0, 4); push(4'hB, 7'h7F, 1, 0, 4);
      push(4'h7, 7'h7F, 1, 0, 4); push(4'hE, 7'h40, 1, 1, 4);
      wait_n(15); load = 1'b1; din = 16'h0050; lzb = 1'b1;
      @(negedge clk); load = 1'b0;
      wait_n(16);
      push(4'hD, 7'h12, 1, 0, 4); push(4'hB, 7'h7F, 1, 0, 4);
      push(4'h7, 7'h7F, 1, 0, 4); push(4'hE, 7'h40, 1, 1, 4);
      push(4'hD, 7'h7F, 1, 0, 4); push(4'hB, 7'h7F, 1, 0, 4);
      push(4'h7, 7'h7F, 1, 0, 4); push(4'hE, 7'h40, 1, 1, 4);
      @(negedge clk); load = 1'b1; din = 16'h0000;
      @(negedge clk); load = 1'b0;
      wait_n(30);

      // Disable mid-digit, load ABCD while disabled, re-enable
      push(4'hF, 7'h7F, 1, 0, 2); push(4'hE, 7'h40, 1, 0, 0);
      push(4'hD, 7'h40, 1, 0, 4); push(4'hB, 7'h40, 1, 0, 4);
      push(4'h7, 7'h40, 1, 0, 4); push(4'hE, G0, 1, 1, 4);
      push(4'hD, G1, 1, 0, 4);    push(4'hB, G2, 1, 0, 4);
      push(4'h7, G3, 1, 0, 4);
      @(negedge clk); en = 1'b0; lzb = 1'b0; load = 1'b1; din = 16'hABCD; dp_mask = 4'b0000;
      @(negedge clk); load = 1'b0;
      wait_n(8); en = 1'b1;
      wait_n(30);

      // Reset mid-frame drops pending 1111
      push(4'hF, 7'h7F, 1, 0, 0); push(4'hE, 7'h40, 1, 0, 0);
      push(4'hD, 7'h40, 1, 0, 4); push(4'hB, 7'h40, 1, 0, 4);
      push(4'h7, 7'h40, 1, 0, 4); push(4'hE, 7'h40, 1, 1, 4);
      push(4'hD, 7'h40, 1, 0, 4); push(4'hF, 7'h7F, 1, 0, 2);
      load = 1'b1; din = 16'h1111; dp_mask = 4'b1111;
      @(negedge clk); load = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midrst_an", 32'(an), 32'hF);
      chk("midrst_seg", 32'(seg), 32'h7F);
      chk("midrst_dp", 32'(dp), 32'd1);
      chk("midrst_pend_v", 32'(u_dut.pend_v), 32'd0);
      @(negedge clk); reset = 1'b0;
      wait_n(22);

      // Single-digit build: an stays low, frame_done on every tick
      en = 1'b0; en1 = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("one_an", 32'(an1), 32'd0);
         chk("one_fd", 32'(fd1), 32'((k != 0) && (k % 4 == 0)));
         if (k == 0) chk("one_seg", 32'(seg1), 32'h40);
      end

      wait_n(2);
      chk("sb_drain", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
